// File: rtl/jk_seq_driver.sv
// Stimulus master for an external JK flip-flop: buffers target Q bits, drives J/K, checks Q.
// Define JK_DRV_TOGGLE_EN to drive every state change as a toggle (J=K=1).
module jk_seq_driver #(
    parameter int DEPTH = 4,
    parameter int CW    = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    input  logic          in_bit,
    output logic          in_ready,
    input  logic          clr_err,
    input  logic          q_fb,
    output logic          j,
    output logic          k,
    output logic          err,
    output logic [CW-1:0] err_cnt,
    output logic          busy
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0]   FULL_CNT = (AW+1)'(DEPTH);
    localparam logic [CW-1:0] ERR_MAX  = '1;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_DRIVE = 2'd1;
    localparam logic [1:0] S_CHECK = 2'd2;

    logic [1:0]       state_q, state_d;
    logic [DEPTH-1:0] mem_q;
    logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
    logic [AW:0]      cnt_q;
    logic             tgt_q, j_q, k_q, err_q;
    logic [CW-1:0]    err_cnt_q;

    logic push, pop, head, mism, j_d, k_d;

    assign in_ready = (cnt_q != FULL_CNT);
    assign push     = in_valid & in_ready;
    assign head     = mem_q[rd_ptr_q];

    // CHECK pops straight into DRIVE so queued bits stream at two cycles each.
    always_comb begin
        state_d = state_q;
        pop     = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (cnt_q != '0) begin
                    pop     = 1'b1;
                    state_d = S_DRIVE;
                end
            end
            S_DRIVE: state_d = S_CHECK;
            S_CHECK: begin
                if (cnt_q != '0) begin
                    pop     = 1'b1;
                    state_d = S_DRIVE;
                end else begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // J/K are nonzero only on a pop edge, so they fall back to 0 after one DRIVE cycle.
`ifdef JK_DRV_TOGGLE_EN
    assign j_d = pop & (q_fb ^ head);
    assign k_d = pop & (q_fb ^ head);
`else
    assign j_d = pop & ~q_fb & head;
    assign k_d = pop & q_fb & ~head;
`endif

    assign mism = (state_q == S_CHECK) && (q_fb != tgt_q);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= S_IDLE;
            mem_q     <= '0;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            cnt_q     <= '0;
            tgt_q     <= 1'b0;
            j_q       <= 1'b0;
            k_q       <= 1'b0;
            err_q     <= 1'b0;
            err_cnt_q <= '0;
        end else begin
            state_q <= state_d;
            j_q     <= j_d;
            k_q     <= k_d;
            err_q   <= mism;
            if (push) begin
                mem_q[wr_ptr_q] <= in_bit;
                wr_ptr_q        <= wr_ptr_q + AW'(1);
            end
            if (pop) begin
                tgt_q    <= head;
                rd_ptr_q <= rd_ptr_q + AW'(1);
            end
            case ({push, pop})
                2'b10:   cnt_q <= cnt_q + (AW+1)'(1);
                2'b01:   cnt_q <= cnt_q - (AW+1)'(1);
                default: cnt_q <= cnt_q;
            endcase
            if (clr_err)
                err_cnt_q <= '0;
            else if (mism && err_cnt_q != ERR_MAX)
                err_cnt_q <= err_cnt_q + CW'(1);
        end
    end

    assign j       = j_q;
    assign k       = k_q;
    assign err     = err_q;
    assign err_cnt = err_cnt_q;
    assign busy    = (state_q != S_IDLE) | (cnt_q != '0);

endmodule

// File: tb/tb_jk_seq_driver.sv
// Randomized bench for jk_seq_driver against a transaction-level timing model and a JK flop.
module tb_jk_seq_driver;
    localparam int DEPTH = 4;
    localparam int CW    = 2;
    localparam int MAXC  = (1 << CW) - 1;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          in_valid = 1'b0, in_bit = 1'b0, clr_err = 1'b0;
    logic          in_ready, q_fb, j, k, err, busy;
    logic [CW-1:0] err_cnt;
    logic          ffq;
    logic          tie0 = 1'b0;

    int n_chk = 0, n_fail = 0;

    // model state
    bit   mq[$];
    int   cyc = 0, last_pop = -10, chk_edge = -10, ecnt = 0;
    logic qm = 1'b0, pend = 1'b0;

    jk_seq_driver #(.DEPTH(DEPTH), .CW(CW)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_bit(in_bit), .in_ready(in_ready),
        .clr_err(clr_err), .q_fb(q_fb), .j(j), .k(k), .err(err), .err_cnt(err_cnt), .busy(busy)
    );

    always #5 clk = ~clk;

    // external flop under test, sharing the reset
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) ffq <= 1'b0;
        else case ({j, k})
            2'b10:   ffq <= 1'b1;
            2'b01:   ffq <= 1'b0;
            2'b11:   ffq <= ~ffq;
            default: ffq <= ffq;
        endcase
    end
    assign q_fb = tie0 ? 1'b0 : ffq;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic logic [1:0] excite(input logic q, input logic t);
        if (q == t) return 2'b00;
`ifdef JK_DRV_TOGGLE_EN
        return 2'b11;
`else
        return t ? 2'b10 : 2'b01;
`endif
    endfunction

    // Called at a falling edge: apply inputs, predict the next rising edge, check after it.
    task automatic cycle(input logic v, input logic b, input logic c, output logic acc);
        int e;
        logic pop, t, qn, eerr;
        logic [1:0] ejk;
        e = cyc + 1;
        in_valid = v; in_bit = b; clr_err = c;
        chk("in_ready", 32'(in_ready), 32'(mq.size() < DEPTH));
        acc  = v && (mq.size() < DEPTH);
        eerr = (chk_edge == e) && pend;
        pop  = (mq.size() != 0) && (e >= last_pop + 2);
        ejk  = 2'b00;
        if (pop) begin
            t        = mq.pop_front();
            ejk      = excite(qm, t);
            qn       = tie0 ? 1'b0 : t;
            pend     = (qn != t);
            qm       = qn;
            last_pop = e;
            chk_edge = e + 2;
        end
        if (acc) mq.push_back(b);
        if (c) ecnt = 0;
        else if (eerr && ecnt < MAXC) ecnt++;
        @(posedge clk);
        cyc = e;
        @(negedge clk);
        chk("j", 32'(j), 32'(ejk[1]));
        chk("k", 32'(k), 32'(ejk[0]));
        chk("err", 32'(err), 32'(eerr));
        chk("err_cnt", 32'(err_cnt), 32'(ecnt));
        chk("busy", 32'(busy), 32'(mq.size() != 0 || e < last_pop + 2));
    endtask

    task automatic do_reset();
        in_valid = 1'b0; clr_err = 1'b0;
        rst = 1'b0;
        #1;
        chk("rst_j", 32'(j), 32'd0);
        chk("rst_k", 32'(k), 32'd0);
        chk("rst_err", 32'(err), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_err_cnt", 32'(err_cnt), 32'd0);
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        mq.delete();
        qm = 1'b0; pend = 1'b0; ecnt = 0; last_pop = -10; chk_edge = -10;
        #2 rst = 1'b1;
    endtask

    task automatic push_seq(input logic [7:0] bits, input int n);
        int i = 0;
        logic acc;
        for (int g = 0; g < 100 && i < n; g++) begin
            cycle(1'b1, bits[i], 1'b0, acc);
            if (acc) i++;
        end
        chk("push_done", 32'(i), 32'(n));
    endtask

    task automatic drain();
        logic acc;
        for (int g = 0; g < 60 && (mq.size() != 0 || cyc < last_pop + 2); g++)
            cycle(1'b0, 1'b0, 1'b0, acc);
        cycle(1'b0, 1'b0, 1'b0, acc);
    endtask

    initial begin
        logic acc, saw_full, found;
        int i;
        logic [7:0] sb;
        repeat (2) @(negedge clk);
        do_reset();

        // correct flop, 1,0,1,1 back-to-back
        tie0 = 1'b0;
        push_seq(8'b0000_1101, 4);
        drain();
        chk("seq_err_cnt", 32'(err_cnt), 32'd0);

        // q_fb stuck at 0: three errors, then clear racing the 4th increment
        do_reset();
        tie0 = 1'b1;
        push_seq(8'b0000_0111, 3);
        drain();
        chk("stuck_err_cnt", 32'(err_cnt), 32'd3);
        push_seq(8'b0000_0001, 1);
        for (int g = 0; g < 10; g++)
            cycle(1'b0, 1'b0, (chk_edge == cyc + 1) && pend, acc);
        chk("clr_priority", 32'(err_cnt), 32'd0);

        // saturation
        do_reset();
        tie0 = 1'b1;
        push_seq(8'b0011_1111, 6);
        drain();
        chk("saturate", 32'(err_cnt), 32'(MAXC));

        // backpressure: hold in_valid high until the FIFO fills
        do_reset();
        tie0 = 1'b1;
        saw_full = 1'b0;
        sb = 8'b1011_0101;
        i = 0;
        for (int g = 0; g < 100 && i < 8; g++) begin
            if (!in_ready) saw_full = 1'b1;
            cycle(1'b1, sb[i], 1'b0, acc);
            if (acc) i++;
        end
        chk("stall_pushed", 32'(i), 32'd8);
        chk("stall_full_seen", 32'(saw_full), 32'd1);
        drain();

        // random traffic, correct flop then stuck flop
        for (int tie = 0; tie < 2; tie++) begin
            do_reset();
            tie0 = tie[0];
            for (int g = 0; g < 300; g++)
                cycle(1'($urandom_range(1, 0)), 1'($urandom_range(1, 0)),
                      ($urandom_range(19, 0) == 0), acc);
            drain();
        end

        // reset while in CHECK with bits still queued
        do_reset();
        tie0 = 1'b0;
        push_seq(8'b0000_1010, 4);
        found = 1'b0;
        for (int g = 0; g < 10 && !found; g++) begin
            if (cyc == last_pop + 1 && mq.size() >= 2) found = 1'b1;
            else cycle(1'b0, 1'b0, 1'b0, acc);
        end
        chk("reached_check", 32'(found), 32'd1);
        do_reset();
        cycle(1'b0, 1'b0, 1'b0, acc);
        chk("post_rst_in_ready", 32'(in_ready), 32'd1);
        chk("post_rst_err_cnt", 32'(err_cnt), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
